sipo_comma_aligner: RTL and testbench
=====================================

# sipo_comma_aligner

Receive-side deserializer that sits directly downstream of the PISO serializer in the SerDes datapath. It shifts in the serial bit stream one bit per clock and searches for a K28.5 comma to find the 10-bit word boundary. Once locked, it emits one aligned 10-bit parallel word every 10 clocks with a valid strobe. It also tracks comma placement, so a bit-slip in the link drops lock and restarts the search automatically.

## Interface
Parameters:
- `COMMA_N`, default `10'b0011111010`: K28.5 pattern, RD−, in transmit order.
- `COMMA_P`, default `10'b1100000101`: K28.5 pattern, RD+, in transmit order.
- `LOSS_THRESH`, default 2: number of consecutive misaligned commas that forces loss of lock. Legal range 1..7.

Ports:
- `clk`, input, 1: single clock; one serial bit per rising edge.
- `rst`, input, 1: reset, synchronous, active-low.
- `ser_in`, input, 1: serial data; bit order is MSB first (word[9] arrives first), matching the PISO output.
- `align_en`, input, 1: permits the block to acquire lock while in HUNT. Ignored while LOCKED.
- `par_out`, output, 10: aligned word; the first-received bit is at [9]. Holds its value between strobes.
- `par_valid`, output, 1: one-cycle strobe; `par_out` carries a new word.
- `aligned`, output, 1: high while in LOCKED.
- `comma_det`, output, 1: one-cycle strobe, coincident with `par_valid`, when the emitted word is `COMMA_N` or `COMMA_P`.

## Operation
- Shift register: `sr_next = {sr[8:0], ser_in}` every cycle, in both states. All pattern compares use `sr_next`.
- `match` is true when `sr_next` equals `COMMA_N` or `COMMA_P`.
- Bit counter `bcnt` runs 0..9. It is only meaningful in LOCKED.
- State HUNT:
  - `aligned=0`, no `par_valid`.
  - If `match` and `align_en=1`: go to LOCKED, set `bcnt`←0, `par_out`←`sr_next`, pulse `par_valid` and `comma_det`, and clear `miss`←0.
  - If `match` and `align_en=0`: stay in HUNT.
- State LOCKED:
  - `bcnt` increments each cycle and wraps 9→0.
  - When the incremented value wraps to 0 (the 10th bit since the previous boundary): `par_out`←`sr_next` and `par_valid` pulses.
  - If that boundary word is also `match`: pulse `comma_det` and set `miss`←0.
- Misaligned comma: `match` in LOCKED at a non-boundary cycle increments `miss` (3-bit, saturating).
  - If the incremented `miss` equals `LOSS_THRESH`: go to HUNT, `miss`←0, `aligned` falls.
  - No `par_valid` is produced on that cycle; the partial word is discarded.
- Non-comma boundary words do not affect `miss`. Only an aligned comma clears it.
- Simultaneous events:
  - A boundary word that is a comma counts as aligned, never as misaligned.
  - A loss-of-lock transition happens only on non-boundary cycles, so it never coincides with `par_valid`.
- Re-entering HUNT retains `sr`. A comma completing in the very next cycle may re-lock immediately.
- Disparity and code-group errors are not checked. Only the two comma patterns are recognised.

## Timing
- Reset values:
  - `par_out=10'h000`, `par_valid=0`, `aligned=0`, `comma_det=0`.
  - `sr=0`, `bcnt=0`, `miss=0`, state HUNT.
- `rst=0` at a rising edge overrides all other activity, including mid-word and LOCKED. Any partial word is lost.
- All outputs are registered. If the last bit of a word is sampled at edge k, then `par_out`, `par_valid` and `comma_det` are valid in the cycle after edge k.
- `aligned` rises at the same edge as the lock `par_valid` and falls at the edge where the loss threshold is reached.
- In LOCKED with no disturbance, `par_valid` has a period of exactly 10 cycles. It is never asserted in consecutive cycles.
- Throughput: one word per 10 clocks. There is no backpressure; the consumer must accept every strobe.

## Test plan
1. Reset then idle:
   - Stimulus: hold `rst=0` for 2 cycles, then stream the repeated word `10'b1010101010` with `align_en=1` for 200 cycles.
   - Required: all outputs stay 0 and no lock occurs, because that stream never contains a comma.
2. Acquire lock:
   - Stimulus: after 3 random bits, send `COMMA_N`, then words `10'h2AA`, `10'h155`, `10'h3FF` MSB first.
   - Required: `par_valid` and `comma_det` fire one cycle after the comma's last bit, with `par_out=0FA`. Then `2AA`, `155`, `3FF` appear at exactly 10-cycle intervals with `comma_det=0`, and `aligned=1` throughout.
3. `align_en` gating:
   - Stimulus: send `COMMA_P` with `align_en=0`, then raise `align_en` and send `COMMA_P` again.
   - Required: the first comma is ignored. Lock occurs on the second with `par_out=305`.
4. Bit-slip loss and relock:
   - Stimulus: while locked, insert one extra bit, then send `COMMA_N` twice (`LOSS_THRESH=2`).
   - Required: `aligned` falls one cycle after the second misaligned comma completes, with no `par_valid` on that cycle. The next `COMMA_N` relocks at the new phase.
5. Miss reset:
   - Stimulus: one misaligned comma, then one aligned comma, then one misaligned comma.
   - Required: lock is retained and `aligned` stays 1.
6. Reset mid-word:
   - Stimulus: assert `rst=0` for 1 cycle at `bcnt=5` while locked.
   - Required: outputs return to reset values the next cycle, and no `par_valid` occurs until a new comma is received.

Source files
------------

// File: rtl/sipo_comma_aligner.sv
// Receive-side deserializer: shifts in the serial stream MSB first, locks onto K28.5 commas
// and emits one aligned 10-bit word every 10 clocks, dropping lock after repeated misaligned commas.
module sipo_comma_aligner #(
    parameter logic [9:0]  COMMA_N     = 10'b0011111010,
    parameter logic [9:0]  COMMA_P     = 10'b1100000101,
    parameter int unsigned LOSS_THRESH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ser_in,
    input  logic       align_en,
    output logic [9:0] par_out,
    output logic       par_valid,
    output logic       aligned,
    output logic       comma_det
);

    localparam logic [0:0] HUNT       = 1'b0;
    localparam logic [0:0] LOCKED     = 1'b1;
    localparam logic [2:0] LOSS_LIMIT = 3'(LOSS_THRESH);

    logic [0:0] state_q, state_d;
    logic [9:0] sr_q, sr_d;
    logic [3:0] bcnt_q, bcnt_d;
    logic [2:0] miss_q, miss_d;
    logic [9:0] par_out_q, par_out_d;
    logic       par_valid_q, par_valid_d;
    logic       comma_det_q, comma_det_d;

    logic       match;
    logic [3:0] bcnt_inc;
    logic [2:0] miss_inc;

    always_comb begin
        sr_d        = {sr_q[8:0], ser_in};
        match       = (sr_d == COMMA_N) || (sr_d == COMMA_P);
        bcnt_inc    = (bcnt_q == 4'd9) ? 4'd0 : bcnt_q + 4'd1;
        miss_inc    = (miss_q == 3'd7) ? 3'd7 : miss_q + 3'd1;

        state_d     = state_q;
        bcnt_d      = bcnt_q;
        miss_d      = miss_q;
        par_out_d   = par_out_q;
        par_valid_d = 1'b0;
        comma_det_d = 1'b0;

        if (state_q == HUNT) begin
            if (match && align_en) begin
                state_d     = LOCKED;
                bcnt_d      = 4'd0;
                miss_d      = 3'd0;
                par_out_d   = sr_d;
                par_valid_d = 1'b1;
                comma_det_d = 1'b1;
            end
        end else begin
            bcnt_d = bcnt_inc;
            if (bcnt_inc == 4'd0) begin
                // A comma on the word boundary is aligned, so it only ever clears the miss count.
                par_out_d   = sr_d;
                par_valid_d = 1'b1;
                if (match) begin
                    comma_det_d = 1'b1;
                    miss_d      = 3'd0;
                end
            end else if (match) begin
                if (miss_inc == LOSS_LIMIT) begin
                    state_d = HUNT;
                    miss_d  = 3'd0;
                    bcnt_d  = 4'd0;
                end else begin
                    miss_d = miss_inc;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= HUNT;
            sr_q        <= 10'd0;
            bcnt_q      <= 4'd0;
            miss_q      <= 3'd0;
            par_out_q   <= 10'd0;
            par_valid_q <= 1'b0;
            comma_det_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bcnt_q      <= bcnt_d;
            miss_q      <= miss_d;
            par_out_q   <= par_out_d;
            par_valid_q <= par_valid_d;
            comma_det_q <= comma_det_d;
        end
    end

    assign par_out   = par_out_q;
    assign par_valid = par_valid_q;
    assign comma_det = comma_det_q;
    assign aligned   = (state_q == LOCKED);

endmodule

// File: tb/tb_sipo_comma_aligner.sv
// Self-checking bench for sipo_comma_aligner: word table plus hand-built slip, miss-reset
// and mid-word reset sequences, with every strobe checked against a queue of expected words.
module tb_sipo_comma_aligner;

    typedef struct {
        logic [9:0] word;
        logic       en;
        logic       exp_valid;
        logic       exp_comma;
        logic       exp_aligned;
    } vec_t;

    typedef struct {
        logic [9:0] word;
        logic       comma;
        int         cyc;
    } exp_t;

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic       ser_in   = 1'b0;
    logic       align_en = 1'b0;
    logic [9:0] par_out;
    logic       par_valid;
    logic       aligned;
    logic       comma_det;

    int         compared   = 0;
    int         mismatched = 0;
    int         cyc_cnt    = 0;
    exp_t       exp_q[$];
    exp_t       mon_e;
    vec_t       vecs[7];

    logic [9:0] cn = 10'h0FA;
    logic [49:0] seq5;
    logic [9:0] w5[5];
    logic       c5[5];

    sipo_comma_aligner dut (
        .clk       (clk),
        .rst       (rst),
        .ser_in    (ser_in),
        .align_en  (align_en),
        .par_out   (par_out),
        .par_valid (par_valid),
        .aligned   (aligned),
        .comma_det (comma_det)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt++;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    // Every strobe must match the oldest queued word, including the cycle it was due in.
    always @(negedge clk) begin
        if (par_valid) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_valid", 32'(par_valid), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_output("par_out", 32'(par_out), 32'(mon_e.word));
                check_output("comma_det", 32'(comma_det), 32'(mon_e.comma));
                check_output("valid_cycle", 32'(cyc_cnt), 32'(mon_e.cyc));
            end
        end else begin
            check_output("comma_det_idle", 32'(comma_det), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic send_bit(input logic b, input logic en);
        @(negedge clk);
        rst      = 1'b1;
        ser_in   = b;
        align_en = en;
    endtask

    task automatic push_exp(input logic [9:0] w, input logic cm);
        exp_t e;
        e.word  = w;
        e.comma = cm;
        e.cyc   = cyc_cnt + 1;
        exp_q.push_back(e);
    endtask

    task automatic send_word(input logic [9:0] w, input logic en);
        for (int i = 9; i >= 0; i--) send_bit(w[i], en);
    endtask

    task automatic apply_stimulus(input vec_t v);
        for (int i = 9; i >= 0; i--) send_bit(v.word[i], v.en);
        if (v.exp_valid) push_exp(v.word, v.exp_comma);
        check_output("aligned_pre", 32'(aligned), 32'(v.exp_aligned));
    endtask

    task automatic do_reset(input int n);
        repeat (n) begin
            @(negedge clk);
            rst      = 1'b0;
            ser_in   = 1'b0;
            align_en = 1'b0;
        end
        send_bit(1'b0, 1'b0);
        check_output("reset_par_out", 32'(par_out), 32'd0);
        check_output("reset_par_valid", 32'(par_valid), 32'd0);
        check_output("reset_aligned", 32'(aligned), 32'd0);
        check_output("reset_comma_det", 32'(comma_det), 32'd0);
        check_output("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        vecs[0] = '{10'h0FA, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{10'h2AA, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{10'h155, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{10'h3FF, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{10'h305, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{10'h305, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{10'h2AA, 1'b1, 1'b1, 1'b0, 1'b1};
        seq5 = {5'b10101, cn, 5'b10101, cn, 5'b10101, cn, 5'b10101};
        w5   = '{10'h2A7, 10'h355, 10'h0FA, 10'h2A7, 10'h355};
        c5   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        $display("[TB] reset then comma-free stream");
        do_reset(2);
        for (int w = 0; w < 20; w++) send_word(10'h2AA, 1'b1);
        check_output("idle_aligned", 32'(aligned), 32'd0);
        check_output("idle_par_out", 32'(par_out), 32'd0);

        $display("[TB] acquire lock and stream words");
        for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(1, 0)), 1'b1);
        for (int i = 0; i < 4; i++) apply_stimulus(vecs[i]);

        $display("[TB] align_en gating");
        do_reset(2);
        for (int i = 4; i < 7; i++) apply_stimulus(vecs[i]);

        $display("[TB] bit slip, loss of lock and relock");
        send_bit(1'b0, 1'b1);
        for (int i = 9; i >= 1; i--) send_bit(cn[i], 1'b1);
        push_exp(10'h07D, 1'b0);
        send_bit(cn[0], 1'b1);
        for (int i = 9; i >= 1; i--) send_bit(cn[i], 1'b1);
        push_exp(10'h07D, 1'b0);
        send_bit(cn[0], 1'b1);
        check_output("aligned_before_loss", 32'(aligned), 32'd1);
        send_bit(cn[9], 1'b1);
        check_output("aligned_after_loss", 32'(aligned), 32'd0);
        for (int i = 8; i >= 1; i--) send_bit(cn[i], 1'b1);
        send_bit(cn[0], 1'b1);
        push_exp(10'h0FA, 1'b1);

        $display("[TB] aligned comma clears miss count");
        for (int k = 49; k >= 0; k--) begin
            send_bit(seq5[k], 1'b1);
            if (((50 - k) % 10) == 0) push_exp(w5[(50 - k) / 10 - 1], c5[(50 - k) / 10 - 1]);
        end
        check_output("aligned_miss_reset", 32'(aligned), 32'd1);

        $display("[TB] reset mid-word while locked");
        for (int i = 0; i < 5; i++) send_bit(1'(i % 2 == 0), 1'b1);
        do_reset(1);
        send_word(10'h2AA, 1'b1);
        send_word(10'h2AA, 1'b1);
        check_output("post_reset_aligned", 32'(aligned), 32'd0);
        apply_stimulus(vecs[0]);
        apply_stimulus(vecs[2]);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        check_output("final_queue_drained", 32'(exp_q.size()), 32'd0);
        check_output("final_aligned", 32'(aligned), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
